// File: rtl/axis_combiner.sv
// Merges two tvalid-only sample streams into one registered stream using a round-robin arbiter.
// Each input has a one-deep hold register. tuser carries the source channel, and the sample width is converted MSB-aligned.
module axis_combiner #(
  parameter int SAXIS_TDATA_WIDTH = 16,
  parameter int MAXIS_TDATA_WIDTH = 32,
  parameter int DROP_CNT_WIDTH    = 16
) (
  input  logic                         a_clk,
  input  logic                         reset,
  input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS0_tdata,
  input  logic                         S_AXIS0_tvalid,
  input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS1_tdata,
  input  logic                         S_AXIS1_tvalid,
  output logic [MAXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                         M_AXIS_tvalid,
  output logic                         M_AXIS_tuser,
  output logic [DROP_CNT_WIDTH-1:0]    drop_count0,
  output logic [DROP_CNT_WIDTH-1:0]    drop_count1,
  output logic [MAXIS_TDATA_WIDTH-1:0] monitor
);

  localparam int S = SAXIS_TDATA_WIDTH;
  localparam int M = MAXIS_TDATA_WIDTH;
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX = '1;

  logic [M-1:0]              w_conv0, w_conv1;
  logic [M-1:0]              r_hold0, r_hold1;
  logic                      r_pend0, r_pend1;
  logic                      r_lastGrant;
  logic [M-1:0]              r_tdata, r_monitor;
  logic                      r_tvalid, r_tuser;
  logic [DROP_CNT_WIDTH-1:0] r_drop0, r_drop1;
  logic                      w_any, w_grant, w_take0, w_take1;

  // Keeping the sign bit at the output MSB makes narrowing an arithmetic shift and widening a left shift.
  if (S < M) begin : g_widen
    assign w_conv0 = {S_AXIS0_tdata, {(M-S){1'b0}}};
    assign w_conv1 = {S_AXIS1_tdata, {(M-S){1'b0}}};
  end else if (S > M) begin : g_narrow
    logic w_unused_lsbs;
    assign w_conv0 = S_AXIS0_tdata[S-1 -: M];
    assign w_conv1 = S_AXIS1_tdata[S-1 -: M];
    assign w_unused_lsbs = ^{S_AXIS0_tdata[S-M-1:0], S_AXIS1_tdata[S-M-1:0]};
  end else begin : g_pass
    assign w_conv0 = S_AXIS0_tdata;
    assign w_conv1 = S_AXIS1_tdata;
  end

  always_comb begin
    w_any   = r_pend0 | r_pend1;
    w_grant = (r_pend0 & r_pend1) ? ~r_lastGrant : r_pend1;
    w_take0 = w_any & ~w_grant;
    w_take1 = w_any & w_grant;
  end

  always_ff @(posedge a_clk) begin
    if (reset) begin
      r_hold0     <= '0;
      r_hold1     <= '0;
      r_pend0     <= 1'b0;
      r_pend1     <= 1'b0;
      r_lastGrant <= 1'b1;
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_tuser     <= 1'b0;
      r_monitor   <= '0;
      r_drop0     <= '0;
      r_drop1     <= '0;
    end else begin
      if (w_any) begin
        r_tdata     <= w_grant ? r_hold1 : r_hold0;
        r_monitor   <= w_grant ? r_hold1 : r_hold0;
        r_tvalid    <= 1'b1;
        r_tuser     <= w_grant;
        r_lastGrant <= w_grant;
      end else begin
        r_tdata  <= '0;
        r_tvalid <= 1'b0;
      end

      // A new sample landing on an un-drained hold register overwrites it and counts as an overrun.
      if (S_AXIS0_tvalid) begin
        r_hold0 <= w_conv0;
        r_pend0 <= 1'b1;
        if (r_pend0 && !w_take0 && r_drop0 != DROP_MAX)
          r_drop0 <= r_drop0 + 1'b1;
      end else if (w_take0) begin
        r_pend0 <= 1'b0;
      end

      if (S_AXIS1_tvalid) begin
        r_hold1 <= w_conv1;
        r_pend1 <= 1'b1;
        if (r_pend1 && !w_take1 && r_drop1 != DROP_MAX)
          r_drop1 <= r_drop1 + 1'b1;
      end else if (w_take1) begin
        r_pend1 <= 1'b0;
      end
    end
  end

  assign M_AXIS_tdata  = r_tdata;
  assign M_AXIS_tvalid = r_tvalid;
  assign M_AXIS_tuser  = r_tuser;
  assign monitor       = r_monitor;
  assign drop_count0   = r_drop0;
  assign drop_count1   = r_drop1;

endmodule
